// File: rtl/serial_pattern_checker.sv
// Serial frame receiver that checks each frame against a masked pattern.
// Ports: clk, rst, cs, d, pat, mask in; q, ack_n, err_n, abort, busy, ok_cnt, err_cnt out.
module serial_pattern_checker #(
  parameter int N_BITS     = 4,
  parameter int OUT_CYCLES = 2,
  parameter int MSB_FIRST  = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              d,
  input  logic [N_BITS-1:0] pat,
  input  logic [N_BITS-1:0] mask,
  output logic [N_BITS-1:0] q,
  output logic              ack_n,
  output logic              err_n,
  output logic              abort,
  output logic              busy,
  output logic [CNT_W-1:0]  ok_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int OW = (OUT_CYCLES > 1) ? $clog2(OUT_CYCLES) : 1;
  // One counter serves both bit indexing and strobe timing.
  localparam int CW = (BW > OW) ? BW : OW;
  localparam logic [CW-1:0] LAST_BIT = CW'(N_BITS - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(OUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAT = '1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    EVAL,
    OUT
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     cnt, cnt_nx;
  logic [N_BITS-1:0] sh, sh_nx;
  logic [N_BITS-1:0] q_nx;
  logic [N_BITS-1:0] word;
  logic              ack_nx, err_nx, abort_nx;
  logic [CNT_W-1:0]  ok_nx, errc_nx;
  logic [CNT_W-1:0]  ok_inc, err_inc;
  logic              miss;

  // Shift register holds bits in arrival order; reorder on evaluation.
  always_comb begin
    word = '0;
    for (int i = 0; i < N_BITS; i++) begin
      if (MSB_FIRST != 0) word[i] = sh[N_BITS-1-i];
      else                word[i] = sh[i];
    end
  end

  assign miss    = |((word ^ pat) & mask);
  assign ok_inc  = (ok_cnt == SAT) ? ok_cnt : ok_cnt + CNT_W'(1);
  assign err_inc = (err_cnt == SAT) ? err_cnt : err_cnt + CNT_W'(1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sh_nx    = sh;
    q_nx     = q;
    ack_nx   = ack_n;
    err_nx   = err_n;
    abort_nx = abort;
    ok_nx    = ok_cnt;
    errc_nx  = err_cnt;
    unique case (state)
      IDLE: begin
        if (!cs) begin
          sh_nx[0] = d;
          cnt_nx   = CW'(1);
          state_nx = RECV;
        end
      end
      RECV: begin
        if (cs) begin
          err_nx   = 1'b0;
          abort_nx = 1'b1;
          errc_nx  = err_inc;
          cnt_nx   = '0;
          state_nx = OUT;
        end else begin
          for (int i = 0; i < N_BITS; i++) begin
            if (cnt == CW'(i)) sh_nx[i] = d;
          end
          cnt_nx = cnt + CW'(1);
          if (cnt == LAST_BIT) state_nx = EVAL;
        end
      end
      EVAL: begin
        q_nx = word;
        if (miss) begin
          err_nx  = 1'b0;
          errc_nx = err_inc;
        end else begin
          ack_nx = 1'b0;
          ok_nx  = ok_inc;
        end
        cnt_nx   = '0;
        state_nx = OUT;
      end
      OUT: begin
        if (cnt == LAST_OUT) begin
          ack_nx   = 1'b1;
          err_nx   = 1'b1;
          abort_nx = 1'b0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      q       <= '0;
      ack_n   <= 1'b1;
      err_n   <= 1'b1;
      abort   <= 1'b0;
      busy    <= 1'b0;
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      sh      <= sh_nx;
      q       <= q_nx;
      ack_n   <= ack_nx;
      err_n   <= err_nx;
      abort   <= abort_nx;
      busy    <= (state_nx != IDLE);
      ok_cnt  <= ok_nx;
      err_cnt <= errc_nx;
    end
  end

endmodule

// File: tb/tb_serial_pattern_checker.sv
// Directed bench for serial_pattern_checker.
// Three instances: defaults, 2-bit counters, and 8-bit MSB-first.
module tb_serial_pattern_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       cs0 = 1'b1, d0 = 1'b0;
  logic [3:0] pat0 = 4'b0101, mask0 = 4'b1111;
  logic [3:0] q0;
  logic       ack0, err0, abort0, busy0;
  logic [7:0] ok0, ec0;

  logic       cs1 = 1'b1, d1 = 1'b0;
  logic [3:0] q1;
  logic       ack1, err1, abort1, busy1;
  logic [1:0] ok1, ec1;

  logic       cs2 = 1'b1, d2 = 1'b0;
  logic [7:0] pat2 = 8'h81;
  logic [7:0] q2;
  logic       ack2, err2, abort2, busy2;
  logic [7:0] ok2, ec2;

  serial_pattern_checker u0 (
    .clk(clk), .rst(rst), .cs(cs0), .d(d0),
    .pat(pat0), .mask(mask0), .q(q0),
    .ack_n(ack0), .err_n(err0), .abort(abort0),
    .busy(busy0), .ok_cnt(ok0), .err_cnt(ec0)
  );

  serial_pattern_checker #(.CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .cs(cs1), .d(d1),
    .pat(4'b0101), .mask(4'b1111), .q(q1),
    .ack_n(ack1), .err_n(err1), .abort(abort1),
    .busy(busy1), .ok_cnt(ok1), .err_cnt(ec1)
  );

  serial_pattern_checker #(
    .N_BITS(8), .OUT_CYCLES(3), .MSB_FIRST(1)
  ) u2 (
    .clk(clk), .rst(rst), .cs(cs2), .d(d2),
    .pat(pat2), .mask(8'hFF), .q(q2),
    .ack_n(ack2), .err_n(err2), .abort(abort2),
    .busy(busy2), .ok_cnt(ok2), .err_cnt(ec2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bits[k] is sent at edge k; leaves cs high after edge N-1.
  task automatic frame0(input logic [3:0] bits);
    for (int k = 0; k < 4; k++) begin
      cs0 = 1'b0;
      d0  = bits[k];
      tick();
    end
    cs0 = 1'b1;
  endtask

  task automatic frame2(input logic [7:0] bits);
    for (int k = 0; k < 8; k++) begin
      cs2 = 1'b0;
      d2  = bits[k];
      tick();
    end
    cs2 = 1'b1;
  endtask

  initial begin
    logic [1:0] exp1;
    logic [3:0] seq1;
    seq1 = 4'b0101;

    tick();
    tick();
    chk("rst_ack", ack0, 1);
    chk("rst_err", err0, 1);
    chk("rst_abort", abort0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_q", q0, 0);
    chk("rst_ok", ok0, 0);
    chk("rst_ec", ec0, 0);
    rst = 1'b0;
    tick();

    // Match: d=1,0,1,0
    cs0 = 1'b0; d0 = 1'b1;
    tick();
    chk("m_busy0", busy0, 1);
    d0 = 1'b0; tick();
    d0 = 1'b1; tick();
    d0 = 1'b0; tick();
    cs0 = 1'b1;
    chk("m_ok_pre", ok0, 0);
    chk("m_ack_pre", ack0, 1);
    tick();
    chk("m_q", q0, 4'b0101);
    chk("m_ack4", ack0, 0);
    chk("m_err4", err0, 1);
    chk("m_ok", ok0, 1);
    tick();
    chk("m_ack5", ack0, 0);
    tick();
    chk("m_ack6", ack0, 1);
    chk("m_busy6", busy0, 0);

    // Mismatch: d=1,1,1,0
    frame0(4'b0111);
    tick();
    chk("x_q", q0, 4'b0111);
    chk("x_err4", err0, 0);
    chk("x_ack4", ack0, 1);
    chk("x_abort4", abort0, 0);
    chk("x_ec", ec0, 1);
    chk("x_ok", ok0, 1);
    tick();
    chk("x_err5", err0, 0);
    tick();
    chk("x_err6", err0, 1);

    // Same word, bit 1 masked off
    mask0 = 4'b1101;
    frame0(4'b0111);
    tick();
    chk("k_ack4", ack0, 0);
    chk("k_err4", err0, 1);
    chk("k_ok", ok0, 2);
    chk("k_ec", ec0, 1);
    tick();
    tick();
    chk("k_ack6", ack0, 1);
    mask0 = 4'b1111;

    // Abort: cs high at edge 2
    cs0 = 1'b0; d0 = 1'b1; tick();
    d0 = 1'b0; tick();
    cs0 = 1'b1; tick();
    chk("a_err2", err0, 0);
    chk("a_abort2", abort0, 1);
    chk("a_ack2", ack0, 1);
    chk("a_q", q0, 4'b0111);
    chk("a_ec", ec0, 2);
    chk("a_ok", ok0, 2);
    tick();
    chk("a_err3", err0, 0);
    chk("a_abort3", abort0, 1);
    tick();
    chk("a_err4", err0, 1);
    chk("a_abort4", abort0, 0);
    chk("a_busy4", busy0, 0);

    // Reset at edge 2 of a frame
    cs0 = 1'b0; d0 = 1'b1; tick();
    tick();
    rst = 1'b1; tick();
    chk("r_ack", ack0, 1);
    chk("r_err", err0, 1);
    chk("r_abort", abort0, 0);
    chk("r_busy", busy0, 0);
    chk("r_q", q0, 0);
    chk("r_ok", ok0, 0);
    chk("r_ec", ec0, 0);
    rst = 1'b0; cs0 = 1'b1; tick();
    frame0(4'b0101);
    tick();
    chk("r2_q", q0, 4'b0101);
    chk("r2_ack", ack0, 0);
    chk("r2_ok", ok0, 1);
    tick();
    tick();

    // All-zero mask matches anything
    mask0 = 4'b0000;
    frame0(4'b1100);
    tick();
    chk("z_q", q0, 4'b1100);
    chk("z_ack", ack0, 0);
    chk("z_ok", ok0, 2);
    chk("z_ec", ec0, 0);
    tick();
    tick();

    // Back-to-back with cs held low, 2-bit counters saturate
    cs1 = 1'b0;
    exp1 = 2'd0;
    for (int t = 0; t < 35; t++) begin
      d1 = ((t % 7) < 4) ? seq1[t % 7] : 1'b0;
      tick();
      if ((t % 7) == 4) begin
        if (exp1 != 2'd3) exp1 = exp1 + 2'd1;
        chk("s_ack", ack1, 0);
        chk("s_ok", ok1, exp1);
      end
      if ((t % 7) == 6) chk("s_busy", busy1, 0);
    end
    cs1 = 1'b1;
    chk("s_final", ok1, 3);
    chk("s_q", q1, 4'b0101);
    tick();
    tick();

    // MSB first, symmetric word
    frame2(8'h81);
    tick();
    chk("b_q", q2, 8'h81);
    chk("b_ack8", ack2, 0);
    chk("b_ok", ok2, 1);
    tick();
    chk("b_ack9", ack2, 0);
    tick();
    chk("b_ack10", ack2, 0);
    tick();
    chk("b_ack11", ack2, 1);
    chk("b_busy11", busy2, 0);

    // MSB first, asymmetric word: d=1,1,0,...
    pat2 = 8'hC0;
    frame2(8'h03);
    tick();
    chk("c_q", q2, 8'hC0);
    chk("c_ack", ack2, 0);
    chk("c_ok", ok2, 2);
    chk("c_ec", ec2, 0);
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
